// File: rtl/key_scan.sv
// 4x4 keypad scanner: row strobing, column synchronisation, press/release
// debounce and a one-cycle strobe per accepted key.
module key_scan #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DEB_CYCLES = 10
) (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_value,
  output logic       flag,
  output logic       busy
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN     = 3'b001,
    DEBOUNCE = 3'b010,
    HOLD     = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    key_q, key_d;
  logic [3:0]    row_n_q, row_n_d;
  logic          flag_q, flag_d;
  logic          busy_q, busy_d;
  logic [3:0]    sync1_q, col_s_q;

  // True when exactly one column line is pulled low.
  function automatic logic one_low(input logic [3:0] p);
    logic [3:0] a;
    a = ~p;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  // Column index of the single low bit in a captured pattern.
  function automatic logic [1:0] col_idx(input logic [3:0] p);
    case (p)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Keypad legend: digits, A-D operators, E equals, F clear.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hF;
      4'hD: return 4'h0;
      4'hE: return 4'hE;
      default: return 4'hD;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      sync1_q <= 4'hF;
      col_s_q <= 4'hF;
    end else begin
      sync1_q <= col_n;
      col_s_q <= sync1_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      dwell_q <= '0;
      cnt_q   <= '0;
      pat_q   <= 4'hF;
      key_q   <= 4'h0;
      row_n_q <= 4'b1110;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      row_n_q <= row_n_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: scan rows, confirm a single press, wait for full release.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    key_d   = key_q;
    flag_d  = 1'b0;

    case (state_q)
      SCAN: begin
        if (dwell_q >= DWELL_LAST) begin
          dwell_d = '0;
          if (one_low(col_s_q)) begin
            pat_d   = col_s_q;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s_q == pat_q) begin
          if (cnt_q >= DEB_LAST) begin
            flag_d  = 1'b1;
            key_d   = key_code(row_q, col_idx(pat_q));
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          dwell_d = '0;
          state_d = SCAN;
        end
      end
      HOLD: begin
        if (col_s_q == 4'hF) begin
          if (cnt_q >= DEB_LAST) begin
            cnt_d   = '0;
            dwell_d = '0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
        row_d   = 2'd0;
        dwell_d = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d  = (state_d != SCAN);
    row_n_d = ~(4'b0001 << row_d);
  end

  assign row_n     = row_n_q;
  assign key_value = key_q;
  assign flag      = flag_q;
  assign busy      = busy_q;

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4, SHALL set clock cycles each row is driven; legal range 3..15.
REQ-002 Parameter DEB_CYCLES, default 10, SHALL set consecutive stable samples needed to accept a press or release (10 ms at 1 kHz); legal range 2..255.
REQ-003 CLK_1K  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 col_n  input  4  SHALL be the keypad column sense lines, active-low (pulled high externally), asynchronous to CLK_1K.
REQ-006 row_n  output  4  SHALL be the keypad row drive lines, one-hot active-low.
REQ-007 key_value  output  4  SHALL be the code of the last accepted key, held until the next acceptance.
REQ-008 flag  output  1  SHALL be a one-cycle strobe marking a new key_value, consumed directly by the calculator input controller.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in SCAN.

Function
REQ-010 col_n SHALL pass through a two-flop synchronizer; all decisions use the synchronized value col_s.
REQ-011 FSM SHALL have states SCAN, DEBOUNCE, HOLD, encoded one-hot.
REQ-012 SCAN: row index r (0..3) SHALL drive row_n = ~(1<<r) for SCAN_DIV cycles, then advance r, wrapping 3->0.
REQ-013 SCAN SHALL sample col_s only in the last cycle of each row dwell (covers synchronizer latency).
REQ-014 At that sample, exactly one bit of col_s low -> capture pattern, hold r, clear debounce counter, go DEBOUNCE.
REQ-015 At that sample, col_s all high or two or more bits low -> no capture; continue scanning (multi-key ignored).
REQ-016 DEBOUNCE: each cycle col_s equals captured pattern -> counter +1; any mismatch -> return to SCAN, restarting dwell on the same row.
REQ-017 When counter reaches DEB_CYCLES-1 with a match, next cycle SHALL assert flag for exactly one cycle, update key_value in that same cycle, and enter HOLD.
REQ-018 Key map (row,col) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: F,0,E,D (A-D operators, E equals, F clear).
REQ-019 HOLD: row r stays driven; counter counts consecutive cycles with col_s all high, reset to 0 on any low bit.
REQ-020 HOLD: counter reaching DEB_CYCLES-1 with col_s all high -> SCAN, advancing to row r+1 (wrap).
REQ-021 Holding a key indefinitely SHALL yield exactly one flag (no auto-repeat).
REQ-022 Second key pressed during HOLD SHALL be ignored until full release is accepted.
REQ-023 flag SHALL never assert in consecutive cycles; minimum spacing between flags is 2*DEB_CYCLES+1 cycles.
REQ-024 Dwell and debounce counters SHALL saturate at their terminal value; no wrap-around.

Reset
REQ-025 RST low SHALL asynchronously force: state SCAN, r=0, row_n=4'b1110, key_value=4'h0, flag=0, busy=0, counters 0, synchronizer flops 4'b1111.
REQ-026 RST asserted mid-DEBOUNCE or mid-HOLD SHALL discard the pending press; no flag after release of RST until a fresh full debounce.
REQ-027 First row dwell after RST deassertion SHALL be a full SCAN_DIV cycles on row 0.

Verification
REQ-028 Press key "5" (row1,col1 low) stable 30 cycles, defaults -> one flag, key_value=4'h5, flag exactly DEB_CYCLES cycles after DEBOUNCE entry.
REQ-029 Press "E" with 3 cycles of bounce (toggle) before settling -> DEBOUNCE restarts, one flag, key_value=4'hE; no flag on the bounces.
REQ-030 Hold "A" for 500 cycles, release, press "3" -> exactly two flags, key_value 4'hA then 4'h3.
REQ-031 Press "1" and "2" together (row0, cols 0 and 1 low) -> no flag, busy stays 0.
REQ-032 Release "7" bouncing for 5 cycles then press "7" again -> only one flag per clean press; second flag after release counted DEB_CYCLES stable.
REQ-033 Assert RST during HOLD of "9" -> row_n=4'b1110, flag=0, key_value=4'h0 immediately; no flag while "9" remains pressed past reset until rescan re-debounces it.
